// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision FP operators.
//   EXP_W/FRAC_W/BIAS  : IEEE-754 binary32 field widths and exponent bias
//   QNAN/POS_INF       : canonical quiet NaN and +infinity encodings
//   fp32_t             : packed {sign, exp, frac} view of a binary32 word
//   state_t            : adder sequencing states
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 2 * BIAS + 1;        // all-ones exponent: inf / NaN

  // Working significand: hidden 1 + fraction + guard, round, sticky
  localparam int MANT_W  = FRAC_W + 4;
  // Adder output carries one extra bit for the carry-out
  localparam int SUM_W   = MANT_W + 1;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over the adder result.
//   i_data  : SUM_W-bit value to scan from the MSB down
//   o_count : number of zeros above the most significant 1 (SUM_W when all zero)
module fp_lzc
  import fp_pkg::*;
(
  input  logic [SUM_W-1:0] i_data,
  output logic [4:0]       o_count
);

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    o_count = 5'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (i_data[i]) o_count = 5'(SUM_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_adder.sv
// Multi-cycle IEEE-754 single-precision adder, round-to-nearest-even,
// subnormal inputs and results flushed to zero.
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   A, B   : operands
//   En     : start request, only looked at in IDLE
//   Sum    : result, held until the next operation completes
//   Ready  : result valid level, cleared when the next En is accepted
//   Flags  : {invalid, overflow, underflow, inexact}, only when the
//            FP_ADDER_FLAGS_EN macro is defined
//
// state | meaning
// IDLE  | waiting for En; captures A and B
// ALIGN | unpack, resolve specials, swap and align smaller operand
// ADD   | add or subtract the aligned significands
// NORM  | renormalise to a leading 1 at the hidden-bit position
// ROUND | round to nearest even, range-check, pack result
// DONE  | publish Sum (and Flags), raise Ready
module fp_adder
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        En,
  output logic [31:0] Sum,
  output logic        Ready
`ifdef FP_ADDER_FLAGS_EN
  ,
  output logic [3:0]  Flags
`endif
);

  state_t r_state, w_state_nxt;

  fp32_t               r_a, r_b;
  logic                r_special;
  logic [31:0]         r_special_val;
  logic                r_sign;
  logic                r_sub;
  logic [EXP_W-1:0]    r_exp;
  logic [MANT_W-1:0]   r_mant_l, r_mant_s;
  logic [SUM_W-1:0]    r_sum;
  logic [MANT_W-1:0]   r_mant_n;
  logic signed [9:0]   r_exp_n;
  logic                r_zero;
  logic [31:0]         r_result;

  // ---------------- ALIGN datapath ----------------
  logic w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
  logic w_special;
  logic [31:0] w_special_val;
  logic w_swap;
  fp32_t w_l, w_s;
  logic [EXP_W-1:0]  w_diff;
  logic [MANT_W-1:0] w_mant_s_full, w_shifted, w_mant_s;

  assign w_a_zero = (r_a.exp == '0);
  assign w_b_zero = (r_b.exp == '0);
  assign w_a_inf  = (&r_a.exp) & ~(|r_a.frac);
  assign w_b_inf  = (&r_b.exp) & ~(|r_b.frac);
  assign w_a_nan  = (&r_a.exp) &  (|r_a.frac);
  assign w_b_nan  = (&r_b.exp) &  (|r_b.frac);

  always_comb begin
    w_special     = 1'b1;
    w_special_val = QNAN;
    if (w_a_nan || w_b_nan) begin
      w_special_val = QNAN;
    end else if (w_a_inf && w_b_inf && (r_a.sign != r_b.sign)) begin
      w_special_val = QNAN;
    end else if (w_a_inf) begin
      w_special_val = r_a;
    end else if (w_b_inf) begin
      w_special_val = r_b;
    end else if (w_a_zero && w_b_zero) begin
      // Only -0 + -0 keeps the minus sign under round-to-nearest
      w_special_val = {r_a.sign & r_b.sign, 31'b0};
    end else if (w_a_zero) begin
      w_special_val = r_b;
    end else if (w_b_zero) begin
      w_special_val = r_a;
    end else begin
      w_special     = 1'b0;
    end
  end

  // Both operands are normal here, so {exp,frac} orders magnitudes directly
  assign w_swap        = (r_b[30:0] > r_a[30:0]);
  assign w_l           = w_swap ? r_b : r_a;
  assign w_s           = w_swap ? r_a : r_b;
  assign w_diff        = w_l.exp - w_s.exp;
  assign w_mant_s_full = {1'b1, w_s.frac, 3'b000};

  always_comb begin
    w_shifted = '0;
    w_mant_s  = '0;
    if (w_diff >= 8'd26) begin
      // Entire operand lands below the round bit: only its sticky survives
      w_mant_s = {{(MANT_W-1){1'b0}}, 1'b1};
    end else begin
      w_shifted = w_mant_s_full >> w_diff;
      w_mant_s  = {w_shifted[MANT_W-1:1],
                   w_shifted[0] | (|(w_mant_s_full & ((27'd1 << w_diff) - 27'd1)))};
    end
  end

  // ---------------- NORM datapath ----------------
  logic [4:0]        w_lz, w_shl;
  logic [MANT_W-1:0] w_mant_n;
  logic signed [9:0] w_exp_n;

  fp_lzc u_lzc (
    .i_data  (r_sum),
    .o_count (w_lz)
  );

  // The leading 1 belongs at bit MANT_W-1, one below the carry bit
  assign w_shl = w_lz - 5'd1;

  always_comb begin
    w_mant_n = '0;
    w_exp_n  = '0;
    if (r_sum[SUM_W-1]) begin
      w_mant_n = {r_sum[SUM_W-1:2], r_sum[1] | r_sum[0]};
      w_exp_n  = $signed({2'b00, r_exp}) + 10'sd1;
    end else begin
      w_mant_n = r_sum[MANT_W-1:0] << w_shl;
      w_exp_n  = $signed({2'b00, r_exp}) - $signed({5'b00000, w_shl});
    end
  end

  // ---------------- ROUND datapath ----------------
  logic              w_round_up;
  logic [24:0]       w_mant_r;
  logic signed [9:0] w_exp_r;
  logic [FRAC_W-1:0] w_frac_r;
  logic              w_ovf, w_unf;
  logic [31:0]       w_result;

  assign w_round_up = r_mant_n[2] & (r_mant_n[1] | r_mant_n[0] | r_mant_n[3]);
  assign w_mant_r   = {1'b0, r_mant_n[MANT_W-1:3]} + {24'b0, w_round_up};
  assign w_exp_r    = r_exp_n + $signed({9'b0, w_mant_r[24]});
  assign w_frac_r   = w_mant_r[24] ? w_mant_r[23:1] : w_mant_r[22:0];
  assign w_ovf      = (w_exp_r >= 10'sd255);
  assign w_unf      = (w_exp_r <= 10'sd0);

  always_comb begin
    w_result = {r_sign, w_exp_r[7:0], w_frac_r};
    if (r_special)   w_result = r_special_val;
    else if (r_zero) w_result = 32'h0000_0000;
    else if (w_ovf)  w_result = {r_sign, POS_INF[30:0]};
    else if (w_unf)  w_result = {r_sign, 31'b0};
  end

`ifdef FP_ADDER_FLAGS_EN
  logic [3:0] r_flags;
  logic [3:0] w_flags;

  always_comb begin
    w_flags = {1'b0, w_ovf, w_unf, (|r_mant_n[2:0]) | w_ovf | w_unf};
    if (r_special)   w_flags = {(r_special_val == QNAN), 3'b000};
    else if (r_zero) w_flags = 4'b0000;
  end
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (En) w_state_nxt = S_ALIGN;
      S_ALIGN: w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = S_ROUND;
      S_ROUND: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a           <= '0;
      r_b           <= '0;
      r_special     <= 1'b0;
      r_special_val <= '0;
      r_sign        <= 1'b0;
      r_sub         <= 1'b0;
      r_exp         <= '0;
      r_mant_l      <= '0;
      r_mant_s      <= '0;
      r_sum         <= '0;
      r_mant_n      <= '0;
      r_exp_n       <= '0;
      r_zero        <= 1'b0;
      r_result      <= '0;
      Sum           <= '0;
      Ready         <= 1'b0;
`ifdef FP_ADDER_FLAGS_EN
      r_flags       <= '0;
      Flags         <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (En) begin
            r_a   <= A;
            r_b   <= B;
            Ready <= 1'b0;
          end
        end
        S_ALIGN: begin
          r_special     <= w_special;
          r_special_val <= w_special_val;
          r_sign        <= w_l.sign;
          r_sub         <= w_l.sign ^ w_s.sign;
          r_exp         <= w_l.exp;
          r_mant_l      <= {1'b1, w_l.frac, 3'b000};
          r_mant_s      <= w_mant_s;
        end
        S_ADD: begin
          r_sum <= r_sub ? ({1'b0, r_mant_l} - {1'b0, r_mant_s})
                         : ({1'b0, r_mant_l} + {1'b0, r_mant_s});
        end
        S_NORM: begin
          // Exact cancellation collapses to +0 regardless of operand signs
          r_zero   <= ~(|r_sum);
          r_mant_n <= w_mant_n;
          r_exp_n  <= w_exp_n;
        end
        S_ROUND: begin
          r_result <= w_result;
`ifdef FP_ADDER_FLAGS_EN
          r_flags  <= w_flags;
`endif
        end
        S_DONE: begin
          Sum   <= r_result;
          Ready <= 1'b1;
`ifdef FP_ADDER_FLAGS_EN
          Flags <= r_flags;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_adder.sv
// Directed self-checking bench for fp_adder. Builds with or without
// FP_ADDER_FLAGS_EN; flag checks are added when the macro is defined.
module tb_fp_adder;

  logic        clk;
  logic        reset;
  logic [31:0] A, B;
  logic        En;
  logic [31:0] Sum;
  logic        Ready;
`ifdef FP_ADDER_FLAGS_EN
  logic [3:0]  Flags;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  fp_adder dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .En    (En),
    .Sum   (Sum),
    .Ready (Ready)
`ifdef FP_ADDER_FLAGS_EN
    ,
    .Flags (Flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Start one addition with En held for 'hold' cycles, then check the
  // Ready latency and the result.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_sum, input logic [3:0] exp_flags,
                       input int hold, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    A  = a;
    B  = b;
    En = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_rdy_clr"}, {31'b0, Ready}, 32'd0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i >= hold) En = 1'b0;
      @(posedge clk);
      #1;
      if (Ready) begin
        lat = i;
        break;
      end
    end
    En = 1'b0;
    check_eq({tag, "_lat"}, lat, 32'd5);
    check_eq({tag, "_sum"}, Sum, exp_sum);
`ifdef FP_ADDER_FLAGS_EN
    check_eq({tag, "_flags"}, {28'b0, Flags}, {28'b0, exp_flags});
`else
    if (exp_flags === 4'bxxxx) $display("unused flag argument");
`endif
  endtask

  initial begin
    logic stayed;
    reset = 1'b0;
    A     = '0;
    B     = '0;
    En    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sum", Sum, 32'd0);
    check_eq("rst_ready", {31'b0, Ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // En held two cycles must start exactly one operation
    do_op(32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 2, "one_plus_two");
    stayed = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (!Ready) stayed = 1'b0;
    end
    check_eq("ready_held", {31'b0, stayed}, 32'd1);
    check_eq("sum_held", Sum, 32'h40400000);

    do_op(32'hBFC00000, 32'h40200000, 32'h3F800000, 4'b0000, 1, "mixed_sign");
    do_op(32'hC1200000, 32'hC0C00000, 32'hC1800000, 4'b0000, 1, "both_neg");
    do_op(32'h3F800000, 32'hBF800000, 32'h00000000, 4'b0000, 1, "cancel");
    do_op(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 1, "overflow");
    do_op(32'h7E800000, 32'h7F000000, 32'h7F400000, 4'b0000, 1, "near_max");
    do_op(32'h02000000, 32'h01000000, 32'h02200000, 4'b0000, 1, "near_min");
    do_op(32'h3F800000, 32'h1F000000, 32'h3F800000, 4'b0001, 1, "absorb_pos");
    do_op(32'hC0000000, 32'h1F000000, 32'hC0000000, 4'b0001, 1, "absorb_neg");
    do_op(32'h00000000, 32'h41C80000, 32'h41C80000, 4'b0000, 1, "zero_plus_x");
    do_op(32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1, "inf_minus_inf");
    do_op(32'h00000001, 32'h00000000, 32'h00000000, 4'b0000, 1, "ftz");
    do_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1, "nan_in");

    // Abort in ADD: accept, one more edge into ADD, then pull reset
    @(negedge clk);
    A  = 32'h40000000;
    B  = 32'h40000000;
    En = 1'b1;
    @(posedge clk);
    @(negedge clk);
    En = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("abort_sum", Sum, 32'd0);
    check_eq("abort_ready", {31'b0, Ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    stayed = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (Ready) stayed = 1'b1;
    end
    check_eq("abort_no_ready", {31'b0, stayed}, 32'd0);

    do_op(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 1, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
